// File: rtl/sdram_write_arbiter_if.sv
// Avalon-MM burst write channel shared by the requesters and the SDRAM port.
// master drives the command/data; slave returns waitrequest.
interface sdram_write_arbiter_if #(
  parameter int ADDR_W  = 29,
  parameter int DATA_W  = 64,
  parameter int BURST_W = 8
);
  logic [ADDR_W-1:0]   address;
  logic [BURST_W-1:0]  burstcount;
  logic [DATA_W-1:0]   writedata;
  logic [DATA_W/8-1:0] byteenable;
  logic                write;
  logic                waitrequest;

  modport master (
    output address,
    output burstcount,
    output writedata,
    output byteenable,
    output write,
    input  waitrequest
  );

  modport slave (
    input  address,
    input  burstcount,
    input  writedata,
    input  byteenable,
    input  write,
    output waitrequest
  );
endinterface

// File: rtl/sdram_write_arbiter.sv
// Round-robin, burst-atomic arbiter for two write masters
// sharing the f2h SDRAM write port.
module sdram_write_arbiter #(
  parameter int ADDR_W  = 29,
  parameter int DATA_W  = 64,
  parameter int BURST_W = 8
) (
  input  logic                 clock,
  input  logic                 reset,
  sdram_write_arbiter_if.slave  r0,
  sdram_write_arbiter_if.slave  r1,
  sdram_write_arbiter_if.master m,
  output logic [1:0]           grant,
  output logic                 busy
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    GRANT0 = 2'd1,
    GRANT1 = 2'd2
  } state_t;

  state_t              state;
  logic                last_owner;
  logic [BURST_W-1:0]  beats_left;

  logic [ADDR_W-1:0]   sel_addr;
  logic [BURST_W-1:0]  sel_bc;
  logic [DATA_W-1:0]   sel_data;
  logic [DATA_W/8-1:0] sel_be;
  logic                sel_write;
  logic                accept;
  logic                pick1;
  logic [BURST_W-1:0]  win_bc;

  // Data path follows the registered state only, so
  // m.write never depends on m.waitrequest.
  always_comb begin
    sel_addr       = '0;
    sel_bc         = '0;
    sel_data       = '0;
    sel_be         = '0;
    sel_write      = 1'b0;
    r0.waitrequest = 1'b1;
    r1.waitrequest = 1'b1;
    unique case (1'b1)
      (state == GRANT0): begin
        sel_addr       = r0.address;
        sel_bc         = r0.burstcount;
        sel_data       = r0.writedata;
        sel_be         = r0.byteenable;
        sel_write      = r0.write;
        r0.waitrequest = m.waitrequest;
      end
      (state == GRANT1): begin
        sel_addr       = r1.address;
        sel_bc         = r1.burstcount;
        sel_data       = r1.writedata;
        sel_be         = r1.byteenable;
        sel_write      = r1.write;
        r1.waitrequest = m.waitrequest;
      end
      default: ;
    endcase
  end

  assign m.address    = sel_addr;
  assign m.burstcount = sel_bc;
  assign m.writedata  = sel_data;
  assign m.byteenable = sel_be;
  assign m.write      = sel_write;

  assign accept = sel_write && !m.waitrequest;

  // On contention the requester that did not own
  // the previous burst wins.
  assign pick1  = r1.write && (!r0.write || !last_owner);
  assign win_bc = pick1 ? r1.burstcount : r0.burstcount;

  always_ff @(posedge clock) begin
    if (reset) begin
      state      <= IDLE;
      last_owner <= 1'b1;
      beats_left <= '0;
      grant      <= 2'b00;
      busy       <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (r0.write || r1.write) begin
            state      <= pick1 ? GRANT1 : GRANT0;
            grant      <= pick1 ? 2'b10 : 2'b01;
            busy       <= 1'b1;
            last_owner <= pick1;
            beats_left <= (win_bc == '0) ?
                          BURST_W'(1) : win_bc;
          end
        end
        GRANT0, GRANT1: begin
          if (accept) begin
            beats_left <= beats_left - 1'b1;
            if (beats_left == BURST_W'(1)) begin
              state <= IDLE;
              grant <= 2'b00;
              busy  <= 1'b0;
            end
          end
        end
        default: begin
          state <= IDLE;
          grant <= 2'b00;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sdram_write_arbiter.sv
// Directed bench for sdram_write_arbiter: scripted requesters,
// beat log of accepted SDRAM writes, hand-computed expectations.
module tb_sdram_write_arbiter;

  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;

  sdram_write_arbiter_if r0_if ();
  sdram_write_arbiter_if r1_if ();
  sdram_write_arbiter_if m_if ();

  logic [1:0] grant;
  logic       busy;

  sdram_write_arbiter dut (
    .clock (clock),
    .reset (reset),
    .r0    (r0_if),
    .r1    (r1_if),
    .m     (m_if),
    .grant (grant),
    .busy  (busy)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag,
                     input logic [63:0] got,
                     input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask

  int          r0_len, r0_idx, r0_gap_at, r0_gap_n;
  logic [7:0]  r0_bc;
  logic [63:0] r0_base;
  logic [28:0] r0_addr;
  int          r1_len, r1_idx;
  logic [7:0]  r1_bc;
  logic [63:0] r1_base;
  logic [28:0] r1_addr;
  logic        mwait;
  logic        rst_req;
  logic [63:0] log_q[$];
  logic [63:0] exp_q[$];

  task automatic s0(input int len, input logic [7:0] bc,
                    input logic [63:0] base,
                    input logic [28:0] addr);
    r0_len = len; r0_idx = 0; r0_bc = bc;
    r0_base = base; r0_addr = addr;
    r0_gap_at = -1; r0_gap_n = 0;
  endtask

  task automatic s1(input int len, input logic [7:0] bc,
                    input logic [63:0] base,
                    input logic [28:0] addr);
    r1_len = len; r1_idx = 0; r1_bc = bc;
    r1_base = base; r1_addr = addr;
  endtask

  task automatic drive();
    logic gap;
    gap = (r0_idx == r0_gap_at) && (r0_gap_n > 0);
    if (gap) r0_gap_n--;
    reset               = rst_req;
    r0_if.write         = (r0_idx < r0_len) && !gap;
    r0_if.writedata     = r0_base + 64'(r0_idx);
    r0_if.address       = r0_addr;
    r0_if.burstcount    = r0_bc;
    r0_if.byteenable    = 8'hFF;
    r1_if.write         = (r1_idx < r1_len);
    r1_if.writedata     = r1_base + 64'(r1_idx);
    r1_if.address       = r1_addr;
    r1_if.burstcount    = r1_bc;
    r1_if.byteenable    = 8'h0F;
    m_if.waitrequest    = mwait;
  endtask

  // Inputs are stable from the negedge, so values seen here
  // are the ones the next posedge samples.
  task automatic adv();
    if (!reset) begin
      if (m_if.write && !m_if.waitrequest)
        log_q.push_back(m_if.writedata);
      if (r0_if.write && !r0_if.waitrequest) r0_idx++;
      if (r1_if.write && !r1_if.waitrequest) r1_idx++;
    end
    @(negedge clock);
  endtask

  task automatic cyc();
    adv();
    drive();
    #1;
  endtask

  task automatic chk_log(input string tag);
    chk($sformatf("%s_n", tag), 64'(log_q.size()),
        64'(exp_q.size()));
    for (int i = 0; i < exp_q.size(); i++)
      chk($sformatf("%s_%0d", tag, i),
          (i < log_q.size()) ? log_q[i] : 64'hx, exp_q[i]);
  endtask

  logic [1:0] exp_g [9];

  initial begin
    mwait   = 1'b0;
    rst_req = 1'b1;
    s0(0, 8'd1, 64'h0, 29'h0);
    s1(0, 8'd1, 64'h0, 29'h0);
    drive();
    @(negedge clock);
    #1;
    cyc();
    cyc();
    rst_req = 1'b0;
    cyc();
    chk("rst_grant", 64'(grant), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_mwrite", 64'(m_if.write), 64'd0);
    chk("rst_wr0", 64'(r0_if.waitrequest), 64'd1);
    chk("rst_wr1", 64'(r1_if.waitrequest), 64'd1);

    // single requester, 4-beat burst
    s0(4, 8'd4, 64'hA0, 29'h100);
    log_q.delete();
    cyc();
    chk("t1_idle_grant", 64'(grant), 64'd0);
    chk("t1_idle_wr0", 64'(r0_if.waitrequest), 64'd1);
    for (int i = 0; i < 4; i++) begin
      cyc();
      chk($sformatf("t1_grant%0d", i), 64'(grant), 64'd1);
      chk($sformatf("t1_data%0d", i), m_if.writedata,
          64'hA0 + 64'(i));
      chk($sformatf("t1_wr1_%0d", i),
          64'(r1_if.waitrequest), 64'd1);
      if (i == 0) begin
        chk("t1_addr", 64'(m_if.address), 64'h100);
        chk("t1_bc", 64'(m_if.burstcount), 64'd4);
        chk("t1_be", 64'(m_if.byteenable), 64'hFF);
      end
    end
    cyc();
    chk("t1_end_grant", 64'(grant), 64'd0);
    chk("t1_end_busy", 64'(busy), 64'd0);
    exp_q = '{64'hA0, 64'hA1, 64'hA2, 64'hA3};
    chk_log("t1_log");

    // contention after reset, then round-robin
    s0(0, 8'd1, 64'h0, 29'h0);
    rst_req = 1'b1;
    cyc();
    rst_req = 1'b0;
    s0(4, 8'd2, 64'hB0, 29'h200);
    s1(2, 8'd2, 64'hC0, 29'h300);
    log_q.delete();
    cyc();
    chk("t2_idle_busy", 64'(busy), 64'd0);
    exp_g = '{2'b01, 2'b01, 2'b00, 2'b10, 2'b10,
              2'b00, 2'b01, 2'b01, 2'b00};
    for (int i = 0; i < 9; i++) begin
      cyc();
      chk($sformatf("t2_grant%0d", i), 64'(grant),
          64'(exp_g[i]));
    end
    exp_q = '{64'hB0, 64'hB1, 64'hC0, 64'hC1,
              64'hB2, 64'hB3};
    chk_log("t2_log");

    // backpressure on beat 2 of an r1 burst
    s0(0, 8'd1, 64'h0, 29'h0);
    s1(3, 8'd3, 64'hD0, 29'h400);
    log_q.delete();
    cyc();
    cyc();
    chk("t3_grant", 64'(grant), 64'd2);
    chk("t3_d0", m_if.writedata, 64'hD0);
    chk("t3_wr1_a", 64'(r1_if.waitrequest), 64'd0);
    chk("t3_wr0", 64'(r0_if.waitrequest), 64'd1);
    mwait = 1'b1;
    cyc();
    chk("t3_wr1_b", 64'(r1_if.waitrequest), 64'd1);
    chk("t3_d1_b", m_if.writedata, 64'hD1);
    chk("t3_mw_b", 64'(m_if.write), 64'd1);
    cyc();
    chk("t3_wr1_c", 64'(r1_if.waitrequest), 64'd1);
    chk("t3_d1_c", m_if.writedata, 64'hD1);
    mwait = 1'b0;
    cyc();
    chk("t3_wr1_d", 64'(r1_if.waitrequest), 64'd0);
    chk("t3_d1_d", m_if.writedata, 64'hD1);
    cyc();
    chk("t3_d2", m_if.writedata, 64'hD2);
    cyc();
    chk("t3_end_grant", 64'(grant), 64'd0);
    exp_q = '{64'hD0, 64'hD1, 64'hD2};
    chk_log("t3_log");

    // burstcount 0 means a single beat
    s1(0, 8'd1, 64'h0, 29'h0);
    s0(2, 8'd0, 64'hE0, 29'h500);
    log_q.delete();
    cyc();
    cyc();
    chk("t4_grant_a", 64'(grant), 64'd1);
    cyc();
    chk("t4_idle_grant", 64'(grant), 64'd0);
    chk("t4_idle_busy", 64'(busy), 64'd0);
    cyc();
    chk("t4_grant_b", 64'(grant), 64'd1);
    chk("t4_e1", m_if.writedata, 64'hE1);
    cyc();
    chk("t4_end_grant", 64'(grant), 64'd0);
    exp_q = '{64'hE0, 64'hE1};
    chk_log("t4_log");

    // requester gap holds the grant, r1 waits
    s0(3, 8'd3, 64'hF0, 29'h600);
    r0_gap_at = 1;
    r0_gap_n  = 2;
    log_q.delete();
    cyc();
    cyc();
    chk("t5_grant_a", 64'(grant), 64'd1);
    s1(1, 8'd1, 64'h90, 29'h700);
    for (int i = 0; i < 2; i++) begin
      cyc();
      chk($sformatf("t5_gap_grant%0d", i), 64'(grant), 64'd1);
      chk($sformatf("t5_gap_mw%0d", i), 64'(m_if.write), 64'd0);
      chk($sformatf("t5_gap_wr1_%0d", i),
          64'(r1_if.waitrequest), 64'd1);
    end
    cyc();
    chk("t5_f1", m_if.writedata, 64'hF1);
    chk("t5_wr1_f1", 64'(r1_if.waitrequest), 64'd1);
    cyc();
    chk("t5_f2", m_if.writedata, 64'hF2);
    chk("t5_wr1_f2", 64'(r1_if.waitrequest), 64'd1);
    cyc();
    chk("t5_idle_grant", 64'(grant), 64'd0);
    cyc();
    chk("t5_r1_grant", 64'(grant), 64'd2);
    chk("t5_r1_data", m_if.writedata, 64'h90);
    cyc();
    exp_q = '{64'hF0, 64'hF1, 64'hF2, 64'h90};
    chk_log("t5_log");

    // reset in the middle of an 8-beat r1 burst
    s0(0, 8'd1, 64'h0, 29'h0);
    s1(8, 8'd8, 64'h10, 29'h800);
    log_q.delete();
    cyc();
    cyc();
    cyc();
    chk("t6_d1", m_if.writedata, 64'h11);
    rst_req = 1'b1;
    cyc();
    chk("t6_pre_grant", 64'(grant), 64'd2);
    rst_req = 1'b0;
    s0(1, 8'd1, 64'h55, 29'h900);
    s1(1, 8'd1, 64'h66, 29'hA00);
    cyc();
    chk("t6_rst_mw", 64'(m_if.write), 64'd0);
    chk("t6_rst_grant", 64'(grant), 64'd0);
    chk("t6_rst_busy", 64'(busy), 64'd0);
    chk("t6_rst_wr0", 64'(r0_if.waitrequest), 64'd1);
    chk("t6_rst_wr1", 64'(r1_if.waitrequest), 64'd1);
    cyc();
    chk("t6_r0_wins", 64'(grant), 64'd1);
    chk("t6_r0_data", m_if.writedata, 64'h55);
    cyc();
    chk("t6_gap", 64'(grant), 64'd0);
    cyc();
    chk("t6_r1_next", 64'(grant), 64'd2);
    chk("t6_r1_data", m_if.writedata, 64'h66);
    cyc();
    exp_q = '{64'h10, 64'h11, 64'h55, 64'h66};
    chk_log("t6_log");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
